// File: rtl/spi_sample_sequencer_pkg.sv
// Shared definitions for the SPI sample sequencer: FSM state encoding,
// shared-bus owner codes and the DAC channel-to-address map.
package spi_sample_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADC_GO    = 3'd1,
    ST_ADC_WAIT  = 3'd2,
    ST_ADC_LATCH = 3'd3,
    ST_CALC_WAIT = 3'd4,
    ST_DAC_GO    = 3'd5,
    ST_DAC_WAIT  = 3'd6
  } seq_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_ADC  = 2'b01;
  localparam logic [1:0] OWN_DAC  = 2'b10;

  localparam int ADC_W      = 14;
  localparam int DAC_W      = 12;
  localparam int MAX_DAC_CH = 4;
  localparam int CH_DATA_W  = DAC_W * MAX_DAC_CH;

  // Channel i is written to DAC address i.
  function automatic logic [3:0] dac_addr_of(input logic [1:0] idx);
    return {2'b00, idx};
  endfunction

  function automatic logic [DAC_W-1:0] dac_word_of(input logic [CH_DATA_W-1:0] words,
                                                   input logic [1:0]           idx);
    return words[DAC_W*int'(idx) +: DAC_W];
  endfunction

endpackage

// File: rtl/spi_bus_mux.sv
// Combinational owner-select of the shared SPI pins; the DAC chip select
// is held inactive unless the DAC owns the bus.
module spi_bus_mux
  import spi_sample_sequencer_pkg::*;
(
  input  logic [1:0] owner,
  input  logic       adc_mosi,
  input  logic       adc_sck,
  input  logic       dac_mosi,
  input  logic       dac_sck,
  input  logic       dac_cs_n,
  output logic       spi_mosi,
  output logic       spi_sck,
  output logic       dac_cs
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred for unlisted codes.
    spi_mosi = 1'b0;
    spi_sck  = 1'b0;
    dac_cs   = 1'b1;
    case (owner)
      OWN_ADC: begin
        spi_mosi = adc_mosi;
        spi_sck  = adc_sck;
      end
      OWN_DAC: begin
        spi_mosi = dac_mosi;
        spi_sck  = dac_sck;
        dac_cs   = dac_cs_n;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spi_sample_sequencer.sv
// Per-sample sequencer: one ADC conversion, then up to NUM_DAC_CH DAC writes,
// arbitrating the shared SPI bus and flagging overruns and engine timeouts.
module spi_sample_sequencer
  import spi_sample_sequencer_pkg::*;
#(
  parameter int NUM_DAC_CH  = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [ADC_W-1:0]     adc_in_A,
  input  logic [ADC_W-1:0]     adc_in_B,
  output logic [ADC_W-1:0]     sample_A,
  output logic [ADC_W-1:0]     sample_B,
  output logic                 sample_valid,
  input  logic [CH_DATA_W-1:0] ch_data,
  input  logic                 ch_valid,
  output logic                 dac_start,
  input  logic                 dac_done,
  output logic [DAC_W-1:0]     dac_datain,
  output logic [3:0]           dac_address,
  input  logic                 adc_mosi,
  input  logic                 adc_sck,
  input  logic                 dac_mosi,
  input  logic                 dac_sck,
  input  logic                 dac_cs_n,
  output logic                 SPI_MOSI,
  output logic                 SPI_SCK,
  output logic                 DAC_CS,
  output logic [1:0]           bus_owner,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout
);

  localparam logic [1:0]       LAST_IDX = 2'(NUM_DAC_CH - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  seq_state_e             state, state_next;
  logic [CNT_W-1:0]       wait_cnt;
  logic [1:0]             idx;
  logic [CH_DATA_W-1:0]   ch_reg;
  logic                   in_wait;
  logic                   wait_expired;
  logic                   timeout_hit;

  assign in_wait      = (state == ST_ADC_WAIT) || (state == ST_CALC_WAIT) ||
                        (state == ST_DAC_WAIT);
  assign wait_expired = (wait_cnt == TO_LAST);

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:      if (sample_tick) state_next = ST_ADC_GO;
      ST_ADC_GO:    state_next = ST_ADC_WAIT;
      ST_ADC_WAIT: begin
        if (adc_done) state_next = ST_ADC_LATCH;
        else if (wait_expired) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_ADC_LATCH: state_next = ST_CALC_WAIT;
      ST_CALC_WAIT: begin
        if (ch_valid) state_next = ST_DAC_GO;
        else if (wait_expired) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_DAC_GO:    state_next = ST_DAC_WAIT;
      ST_DAC_WAIT: begin
        if (dac_done) state_next = (idx == LAST_IDX) ? ST_IDLE : ST_DAC_GO;
        else if (wait_expired) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      idx          <= '0;
      ch_reg       <= '0;
      sample_A     <= '0;
      sample_B     <= '0;
      sample_valid <= 1'b0;
      dac_datain   <= '0;
      dac_address  <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state <= state_next;

      // Counter restarts on every state entry and only runs while waiting on an engine.
      if (state_next != state) wait_cnt <= '0;
      else if (in_wait)        wait_cnt <= wait_cnt + CNT_W'(1);
      else                     wait_cnt <= '0;

      if (state == ST_ADC_WAIT && adc_done) begin
        sample_A <= adc_in_A;
        sample_B <= adc_in_B;
      end
      sample_valid <= (state == ST_ADC_LATCH);

      if (state == ST_CALC_WAIT && ch_valid) begin
        ch_reg      <= ch_data;
        idx         <= '0;
        dac_datain  <= dac_word_of(ch_data, 2'd0);
        dac_address <= dac_addr_of(2'd0);
      end else if (state == ST_DAC_WAIT && dac_done && idx != LAST_IDX) begin
        idx         <= idx + 2'd1;
        dac_datain  <= dac_word_of(ch_reg, idx + 2'd1);
        dac_address <= dac_addr_of(idx + 2'd1);
      end

      if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
      if (timeout_hit)                     timeout <= 1'b1;
    end
  end

  assign adc_start = (state == ST_ADC_GO);
  assign dac_start = (state == ST_DAC_GO);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    bus_owner = OWN_NONE;
    if (state == ST_ADC_GO || state == ST_ADC_WAIT)      bus_owner = OWN_ADC;
    else if (state == ST_DAC_GO || state == ST_DAC_WAIT) bus_owner = OWN_DAC;
  end

  spi_bus_mux u_bus_mux (
    .owner    (bus_owner),
    .adc_mosi (adc_mosi),
    .adc_sck  (adc_sck),
    .dac_mosi (dac_mosi),
    .dac_sck  (dac_sck),
    .dac_cs_n (dac_cs_n),
    .spi_mosi (SPI_MOSI),
    .spi_sck  (SPI_SCK),
    .dac_cs   (DAC_CS)
  );

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Directed bench for spi_sample_sequencer: a default-parameter instance plus a
// single-channel instance with a short timeout.
module tb_spi_sample_sequencer;

  localparam int P_TICK = 0, P_ADC = 1, P_CH = 2, P_DAC = 3;
  localparam int P_TICK1 = 4, P_ADC1 = 5, P_CH1 = 6, P_DAC1 = 7;

  logic        clk = 1'b0, rst = 1'b1;
  logic        tick = 1'b0, adc_done = 1'b0, ch_valid = 1'b0, dac_done = 1'b0;
  logic        tick1 = 1'b0, adc_done1 = 1'b0, ch_valid1 = 1'b0, dac_done1 = 1'b0;
  logic [13:0] adc_a = '0, adc_b = '0;
  logic [47:0] ch_data = '0;
  logic        adc_mosi = 1'b0, adc_sck = 1'b0, dac_mosi = 1'b0, dac_sck = 1'b0, dac_cs_n = 1'b1;

  logic        adc_start, dac_start, sample_valid, busy, overrun, timeout;
  logic        spi_mosi, spi_sck, dac_cs;
  logic [13:0] sample_a, sample_b;
  logic [11:0] dac_datain;
  logic [3:0]  dac_address;
  logic [1:0]  bus_owner;

  logic        adc_start1, dac_start1, sample_valid1, busy1, overrun1, timeout1;
  logic        spi_mosi1, spi_sck1, dac_cs1;
  logic [13:0] sample_a1, sample_b1;
  logic [11:0] dac_datain1;
  logic [3:0]  dac_address1;
  logic [1:0]  bus_owner1;

  int n_tests = 0, n_fail = 0;
  int n_adc_start = 0, n_dac_start = 0, n_valid1 = 0, n_dac_start1 = 0;

  spi_sample_sequencer dut (
    .clk(clk), .rst(rst), .sample_tick(tick), .adc_start(adc_start), .adc_done(adc_done),
    .adc_in_A(adc_a), .adc_in_B(adc_b), .sample_A(sample_a), .sample_B(sample_b),
    .sample_valid(sample_valid), .ch_data(ch_data), .ch_valid(ch_valid),
    .dac_start(dac_start), .dac_done(dac_done), .dac_datain(dac_datain),
    .dac_address(dac_address), .adc_mosi(adc_mosi), .adc_sck(adc_sck),
    .dac_mosi(dac_mosi), .dac_sck(dac_sck), .dac_cs_n(dac_cs_n),
    .SPI_MOSI(spi_mosi), .SPI_SCK(spi_sck), .DAC_CS(dac_cs), .bus_owner(bus_owner),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  spi_sample_sequencer #(.NUM_DAC_CH(1), .TIMEOUT_CYC(16), .CNT_W(5)) dut1 (
    .clk(clk), .rst(rst), .sample_tick(tick1), .adc_start(adc_start1), .adc_done(adc_done1),
    .adc_in_A(adc_a), .adc_in_B(adc_b), .sample_A(sample_a1), .sample_B(sample_b1),
    .sample_valid(sample_valid1), .ch_data(ch_data), .ch_valid(ch_valid1),
    .dac_start(dac_start1), .dac_done(dac_done1), .dac_datain(dac_datain1),
    .dac_address(dac_address1), .adc_mosi(adc_mosi), .adc_sck(adc_sck),
    .dac_mosi(dac_mosi), .dac_sck(dac_sck), .dac_cs_n(dac_cs_n),
    .SPI_MOSI(spi_mosi1), .SPI_SCK(spi_sck1), .DAC_CS(dac_cs1), .bus_owner(bus_owner1),
    .busy(busy1), .overrun(overrun1), .timeout(timeout1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (adc_start)     n_adc_start++;
    if (dac_start)     n_dac_start++;
    if (sample_valid1) n_valid1++;
    if (dac_start1)    n_dac_start1++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int sig);
    case (sig)
      P_TICK:  tick      = 1'b1;
      P_ADC:   adc_done  = 1'b1;
      P_CH:    ch_valid  = 1'b1;
      P_DAC:   dac_done  = 1'b1;
      P_TICK1: tick1     = 1'b1;
      P_ADC1:  adc_done1 = 1'b1;
      P_CH1:   ch_valid1 = 1'b1;
      default: dac_done1 = 1'b1;
    endcase
    step();
    {tick, adc_done, ch_valid, dac_done} = 4'b0;
    {tick1, adc_done1, ch_valid1, dac_done1} = 4'b0;
  endtask

  task automatic test_reset();
    {adc_mosi, adc_sck, dac_mosi, dac_sck, dac_cs_n} = 5'b11110;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({adc_start, dac_start, sample_valid, busy, overrun, timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {adc_start, dac_start, sample_valid, busy, overrun, timeout});
    end
    n_tests++;
    if ({bus_owner, spi_mosi, spi_sck, dac_cs} !== 5'b00_001) begin
      n_fail++;
      $display("FAIL reset_bus: got %b expected 00001", {bus_owner, spi_mosi, spi_sck, dac_cs});
    end
    n_tests++;
    if ({sample_a, sample_b, dac_datain, dac_address} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {sample_a, sample_b, dac_datain, dac_address});
    end
    n_tests++;
    if ({busy1, timeout1, dac_cs1} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b expected 001", {busy1, timeout1, dac_cs1});
    end
    rst = 1'b0;
    {adc_mosi, adc_sck, dac_mosi, dac_sck, dac_cs_n} = 5'b00001;
    step();
  endtask

  task automatic test_nominal();
    logic [11:0] exp_data [4];
    exp_data[0] = 12'h444; exp_data[1] = 12'h333; exp_data[2] = 12'h222; exp_data[3] = 12'h111;
    pulse(P_TICK);
    n_tests++;
    if ({adc_start, bus_owner, busy} !== 4'b1011) begin
      n_fail++;
      $display("FAIL nom_adc_start: got %b expected 1011", {adc_start, bus_owner, busy});
    end
    step();
    n_tests++;
    if ({adc_start, bus_owner} !== 3'b001) begin
      n_fail++;
      $display("FAIL nom_adc_wait: got %b expected 001", {adc_start, bus_owner});
    end
    repeat (38) step();
    adc_a = 14'h1ABC; adc_b = 14'h0123;
    pulse(P_ADC);
    adc_a = 14'h3FFF; adc_b = 14'h3FFF;
    n_tests++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_valid_early: got %b expected 0", sample_valid);
    end
    step();
    n_tests++;
    if ({sample_valid, sample_a, sample_b} !== {1'b1, 14'h1ABC, 14'h0123}) begin
      n_fail++;
      $display("FAIL nom_sample: got %b/%h/%h expected 1/1abc/0123", sample_valid, sample_a, sample_b);
    end
    step();
    n_tests++;
    if (sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_valid_pulse: got %b expected 0", sample_valid);
    end
    repeat (3) step();
    ch_data = 48'h111_222_333_444;
    pulse(P_CH);
    ch_data = 48'hFFF_FFF_FFF_FFF;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({dac_start, bus_owner, dac_address, dac_datain} !== {1'b1, 2'b10, 4'(k), exp_data[k]}) begin
        n_fail++;
        $display("FAIL nom_dac_go%0d: got %b/%h/%h expected 1/%h/%h", k, dac_start,
                 dac_address, dac_datain, 4'(k), exp_data[k]);
      end
      step();
      step();
      n_tests++;
      if ({dac_start, dac_address, dac_datain} !== {1'b0, 4'(k), exp_data[k]}) begin
        n_fail++;
        $display("FAIL nom_dac_hold%0d: got %b/%h/%h expected 0/%h/%h", k, dac_start,
                 dac_address, dac_datain, 4'(k), exp_data[k]);
      end
      pulse(P_DAC);
    end
    n_tests++;
    if ({busy, bus_owner, dac_start, timeout, overrun, dac_address, dac_datain} !==
        {5'b0, 4'h3, 12'h111}) begin
      n_fail++;
      $display("FAIL nom_end: got %h expected 0003111",
               {busy, bus_owner, dac_start, timeout, overrun, dac_address, dac_datain});
    end
  endtask

  task automatic test_bus_exclusive();
    logic [1:0] cb, exp_own;
    logic [2:0] exp_pins;
    for (int c = 0; c < 24; c++) begin
      cb       = c[1:0];
      tick     = (c == 0);
      adc_done = (c == 5);
      ch_valid = (c == 8);
      dac_done = (c == 11 || c == 14 || c == 17 || c == 20);
      adc_mosi = cb[0]; adc_sck = ~cb[0];
      dac_mosi = ~cb[0]; dac_sck = cb[0]; dac_cs_n = cb[1];
      if (c >= 1 && c <= 5) begin
        exp_own = 2'b01; exp_pins = {adc_mosi, adc_sck, 1'b1};
      end else if (c >= 9 && c <= 20) begin
        exp_own = 2'b10; exp_pins = {dac_mosi, dac_sck, dac_cs_n};
      end else begin
        exp_own = 2'b00; exp_pins = 3'b001;
      end
      #1;
      n_tests++;
      if ({bus_owner, spi_mosi, spi_sck, dac_cs} !== {exp_own, exp_pins}) begin
        n_fail++;
        $display("FAIL bus_cycle%0d: got %b expected %b", c,
                 {bus_owner, spi_mosi, spi_sck, dac_cs}, {exp_own, exp_pins});
      end
      step();
    end
    {tick, adc_done, ch_valid, dac_done} = 4'b0;
    {adc_mosi, adc_sck, dac_mosi, dac_sck, dac_cs_n} = 5'b00001;
    step();
  endtask

  task automatic test_stray_events();
    int a0, d0;
    a0 = n_adc_start; d0 = n_dac_start;
    pulse(P_CH); pulse(P_ADC); pulse(P_DAC);
    step();
    n_tests++;
    if ({busy, n_adc_start - a0, n_dac_start - d0} !== {1'b0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL stray_idle: got busy=%b adc=%0d dac=%0d expected 0/0/0", busy,
               n_adc_start - a0, n_dac_start - d0);
    end
    pulse(P_TICK);
    step();
    pulse(P_CH); pulse(P_DAC);
    step();
    n_tests++;
    if ({busy, bus_owner, n_dac_start - d0} !== {3'b101, 32'd0}) begin
      n_fail++;
      $display("FAIL stray_adc_wait: got busy=%b owner=%b dac=%0d expected 1/01/0", busy,
               bus_owner, n_dac_start - d0);
    end
    pulse(P_ADC);
    step();
    pulse(P_CH);
    repeat (4) begin
      step();
      pulse(P_DAC);
    end
  endtask

  task automatic test_overrun();
    int a0, d0;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pre: got %b expected 0", overrun);
    end
    a0 = n_adc_start; d0 = n_dac_start;
    pulse(P_TICK);
    step();
    pulse(P_ADC);
    step();
    pulse(P_CH);
    step();
    pulse(P_TICK);
    n_tests++;
    if ({overrun, busy, bus_owner} !== 4'b1110) begin
      n_fail++;
      $display("FAIL ovr_set: got %b expected 1110", {overrun, busy, bus_owner});
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      pulse(P_DAC);
    end
    step();
    step();
    n_tests++;
    if ({busy, overrun, n_adc_start - a0, n_dac_start - d0} !== {2'b01, 32'd1, 32'd4}) begin
      n_fail++;
      $display("FAIL ovr_complete: got busy=%b ovr=%b adc=%0d dac=%0d expected 0/1/1/4",
               busy, overrun, n_adc_start - a0, n_dac_start - d0);
    end
  endtask

  task automatic test_reset_mid_dac();
    int d0;
    pulse(P_TICK);
    step();
    pulse(P_ADC);
    step();
    ch_data = 48'hABC_DEF_123_456;
    pulse(P_CH);
    step();
    pulse(P_DAC);
    step();
    {dac_mosi, dac_sck, dac_cs_n} = 3'b110;
    #1;
    n_tests++;
    if ({overrun, bus_owner, dac_address, dac_datain, spi_mosi, spi_sck, dac_cs} !==
        {1'b1, 2'b10, 4'h1, 12'h123, 3'b110}) begin
      n_fail++;
      $display("FAIL rst_pre: got %b expected %b",
               {overrun, bus_owner, dac_address, dac_datain, spi_mosi, spi_sck, dac_cs},
               {1'b1, 2'b10, 4'h1, 12'h123, 3'b110});
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({overrun, busy, bus_owner, dac_start, dac_address, dac_datain, spi_mosi, spi_sck, dac_cs} !==
        {5'b0, 4'h0, 12'h000, 3'b001}) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected all zero with DAC_CS=1",
               {overrun, busy, bus_owner, dac_start, dac_address, dac_datain, spi_mosi, spi_sck, dac_cs});
    end
    step();
    rst = 1'b0;
    {dac_mosi, dac_sck, dac_cs_n} = 3'b001;
    d0 = n_dac_start;
    step();
    pulse(P_DAC);
    step();
    n_tests++;
    if ({busy, bus_owner, n_dac_start - d0} !== {3'b000, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_stale_done: got busy=%b owner=%b dac=%0d expected 0/00/0", busy,
               bus_owner, n_dac_start - d0);
    end
  endtask

  task automatic test_tick_on_final_done();
    int a0;
    pulse(P_TICK);
    step();
    pulse(P_ADC);
    step();
    pulse(P_CH);
    for (int k = 0; k < 3; k++) begin
      step();
      pulse(P_DAC);
    end
    step();
    a0 = n_adc_start;
    dac_done = 1'b1;
    tick     = 1'b1;
    step();
    {dac_done, tick} = 2'b00;
    n_tests++;
    if ({overrun, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL final_tick_ovr: got %b expected 10", {overrun, busy});
    end
    repeat (3) step();
    n_tests++;
    if ({busy, n_adc_start - a0} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL final_tick_ignored: got busy=%b adc=%0d expected 0/0", busy, n_adc_start - a0);
    end
  endtask

  task automatic test_timeout();
    int v0;
    v0 = n_valid1;
    pulse(P_TICK1);
    step();
    repeat (15) step();
    n_tests++;
    if ({timeout1, busy1, bus_owner1} !== 4'b0101) begin
      n_fail++;
      $display("FAIL to_before: got %b expected 0101", {timeout1, busy1, bus_owner1});
    end
    step();
    n_tests++;
    if ({timeout1, busy1, bus_owner1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_fire: got %b expected 1000", {timeout1, busy1, bus_owner1});
    end
    repeat (3) step();
    n_tests++;
    if ({timeout, n_valid1 - v0} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL to_no_valid: got main_to=%b valid=%0d expected 0/0", timeout, n_valid1 - v0);
    end
  endtask

  task automatic test_single_channel();
    int v0, d0;
    v0 = n_valid1; d0 = n_dac_start1;
    pulse(P_TICK1);
    step();
    pulse(P_ADC1);
    step();
    ch_data = 48'hAAA_BBB_CCC_5A5;
    pulse(P_CH1);
    n_tests++;
    if ({dac_start1, dac_address1, dac_datain1} !== {1'b1, 4'h0, 12'h5A5}) begin
      n_fail++;
      $display("FAIL one_ch_go: got %b/%h/%h expected 1/0/5a5", dac_start1, dac_address1, dac_datain1);
    end
    step();
    pulse(P_DAC1);
    n_tests++;
    if ({busy1, timeout1, n_valid1 - v0} !== {2'b01, 32'd1}) begin
      n_fail++;
      $display("FAIL one_ch_idle: got busy=%b to=%b valid=%0d expected 0/1/1", busy1, timeout1,
               n_valid1 - v0);
    end
    repeat (3) step();
    n_tests++;
    if ({n_dac_start1 - d0, dac_address1, dac_datain1} !== {32'd1, 4'h0, 12'h5A5}) begin
      n_fail++;
      $display("FAIL one_ch_count: got dac=%0d %h/%h expected 1 0/5a5", n_dac_start1 - d0,
               dac_address1, dac_datain1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nominal();
    test_bus_exclusive();
    test_stray_events();
    test_overrun();
    test_reset_mid_dac();
    test_tick_on_final_done();
    test_timeout();
    test_single_channel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sample_sequencer.md
Name: spi_sample_sequencer

Overview:
Sequences the shared SPI bus (SPI_MOSI/SPI_SCK) between the adcread engine and the dacwrite engine once per sample period. On each sample tick it runs one ADC conversion and latches both channels for the sequence-decomposer datapath. It then waits for the decomposer's results and writes up to NUM_DAC_CH words to the DAC, one channel at a time. It owns bus muxing and chip-select gating so the two engines never drive the bus together, and it flags overruns and engine timeouts.

Parameters:
NUM_DAC_CH, 4, number of DAC channels written per sample (1..4); channel i uses DAC address i
TIMEOUT_CYC, 4096, max clk cycles to wait for any engine done or ch_valid before aborting
CNT_W, 13, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  reset, asynchronous, active-high
sample_tick  in  1  one-cycle pulse, start of sample period
adc_start  out  1  one-cycle start pulse to adcread
adc_done  in  1  one-cycle done pulse from adcread
adc_in_A  in  14  ADC channel A result, valid in the adc_done cycle
adc_in_B  in  14  ADC channel B result, valid in the adc_done cycle
sample_A  out  14  latched channel A
sample_B  out  14  latched channel B
sample_valid  out  1  one-cycle pulse, cycle after latch
ch_data  in  48  decomposer outputs; channel i at [12i+11:12i]
ch_valid  in  1  one-cycle pulse, ch_data valid
dac_start  out  1  one-cycle start pulse to dacwrite
dac_done  in  1  one-cycle done pulse from dacwrite
dac_datain  out  12  word for current DAC write
dac_address  out  4  DAC channel address
adc_mosi, adc_sck  in  1 each  adcread SPI drive
dac_mosi, dac_sck, dac_cs_n  in  1 each  dacwrite SPI drive
SPI_MOSI, SPI_SCK  out  1 each  shared bus pins
DAC_CS  out  1  gated DAC chip select (active-low)
bus_owner  out  2  00 none, 01 ADC, 10 DAC
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky; sample_tick arrived while busy
timeout  out  1  sticky; a wait exceeded TIMEOUT_CYC

Behaviour:
- Reset values: all outputs 0, except DAC_CS=1. State IDLE, channel index 0, timeout counter 0. Assertion of rst mid-operation aborts immediately, regardless of state.
- States:
  - IDLE: sample_tick -> ADC_GO.
  - ADC_GO: adc_start=1 for exactly one cycle -> ADC_WAIT.
  - ADC_WAIT: on adc_done, latch A/B -> ADC_LATCH.
  - ADC_LATCH: sample_valid=1 for one cycle -> CALC_WAIT.
  - CALC_WAIT: on ch_valid, capture ch_data into a 48-bit register; idx=0 -> DAC_GO.
  - DAC_GO: dac_datain=word[idx], dac_address=idx, dac_start=1 for one cycle -> DAC_WAIT.
  - DAC_WAIT: on dac_done, if idx==NUM_DAC_CH-1 -> IDLE, else idx+1 -> DAC_GO.
- Latency: adc_start is asserted 1 cycle after sample_tick. sample_valid is asserted 2 cycles after adc_done. The first dac_start comes 1 cycle after ch_valid.
- bus_owner is 01 in ADC_GO/ADC_WAIT and 10 in DAC_GO/DAC_WAIT; otherwise 00.
- Bus mux (registered-free, combinational from bus_owner):
  - 01: SPI_MOSI/SPI_SCK = adc_mosi/adc_sck.
  - 10: SPI_MOSI/SPI_SCK = dac_mosi/dac_sck, and DAC_CS = dac_cs_n.
  - 00: SPI_MOSI=0, SPI_SCK=0, DAC_CS=1.
  - DAC_CS is forced to 1 whenever the DAC is not the owner.
- dac_datain/dac_address hold their value from DAC_GO until the next DAC_GO.
- Timeout: the counter clears on every state entry and increments in ADC_WAIT, CALC_WAIT and DAC_WAIT. When it reaches TIMEOUT_CYC-1 with no event: set timeout, go to IDLE, and do not assert sample_valid again for that sample.
- sample_tick while not IDLE: ignored (not queued); set overrun. A sample_tick in the same cycle as the final dac_done is also an overrun, since the state is not yet IDLE.
- ch_valid outside CALC_WAIT is ignored. adc_done/dac_done outside their wait state are ignored.
- Sticky flags clear only on rst.

Decomposition:
- Shared package: state encoding constants, bus_owner codes (OWN_NONE/OWN_ADC/OWN_DAC) and the DAC address map.
- Sub-module spi_bus_mux: purely combinational owner-select of MOSI/SCK/CS. Keeping it separate lets it be reused by any future SPI client.

Test Plan:
- Nominal cycle: tick; adc_done after 40 cycles with A=14'h1ABC, B=14'h0123; ch_valid with ch_data=48'h111_222_333_444 -> sample_A=1ABC and sample_B=0123 with a sample_valid pulse; four dac_start pulses with (addr,data) = (0,444), (1,333), (2,222), (3,111); back to IDLE.
- Bus exclusivity: toggle all engine SPI inputs every cycle -> SPI pins follow only the owner; DAC_CS=1 throughout the ADC phase and in IDLE.
- Overrun: second tick during DAC_WAIT -> overrun=1; no extra adc_start; the current sequence completes.
- Timeout: withhold adc_done with TIMEOUT_CYC=16 -> timeout=1 exactly 16 cycles after entering ADC_WAIT; IDLE; the next tick runs normally.
- Reset mid-DAC_WAIT: assert rst -> outputs return to reset values immediately (DAC_CS=1, bus_owner=00); after release, a stale dac_done is ignored.
- NUM_DAC_CH=1: a single dac_start at address 0, then IDLE.
